// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry defaults, pattern selects and colour-bar table shared with the VGA reader.
// Latency: none, types and constants only.
// Backpressure: none.
package fb_pkg;

    localparam int FB_HDISP = 800;
    localparam int FB_VDISP = 480;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_GRAD    = 2'd3
    } pat_t;

    // Classic eight-bar order, bar 0 at the left edge. Element 0 is leftmost.
    localparam logic [0:7][23:0] BAR_COLORS = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/fb_pattern_gen.sv
// fb_pattern_gen: maps (pattern, solid colour, x, y) to one 24-bit {R,G,B} pixel.
// Latency: purely combinational, registered by the instantiating writer.
// Backpressure: none; it follows whatever x/y the writer presents.
// Ports: pat/color select the pattern, x/y are the pixel coordinates, pixel is the result.
module fb_pattern_gen
    import fb_pkg::*;
#(
    parameter int HDISP = FB_HDISP,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic [1:0]    pat,
    input  logic [23:0]   color,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [23:0]   pixel
);

    localparam int BAR_W = HDISP / 8;

    logic [2:0] bar;
    logic [7:0] xe;
    logic [7:0] ye;
    logic       unused_y_hi;

    // Only the low byte of y feeds any pattern; the rest is the writer's concern.
    assign unused_y_hi = ^y;

    always_comb begin
        xe    = 8'(x);
        ye    = 8'(y);
        // x / BAR_W as a comparator chain: the last threshold passed wins.
        bar   = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= XW'(k * BAR_W)) begin
                bar = 3'(k);
            end
        end
        pixel = color;
        case (pat_t'(pat))
            PAT_SOLID:   pixel = color;
            PAT_BARS:    pixel = BAR_COLORS[bar];
            PAT_CHECKER: pixel = (xe[4] ^ ye[4]) ? 24'h000000 : 24'hFFFFFF;
            PAT_GRAD:    pixel = {xe, ye, xe + ye};
            default:     pixel = color;
        endcase
    end

endmodule

// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer: Wishbone master filling the linear 32-bit/pixel framebuffer with a test pattern.
// Latency: first write presented the cycle after start; one pixel per cycle against a zero-wait slave.
// Backpressure: address/data held until wb_ack; writes grouped in BURST acks separated by GAP idle cycles.
// Ports: start/continuous/pat/color control a fill, busy/done report it, wb_* is the classic Wishbone master.
module fb_pattern_writer
    import fb_pkg::*;
#(
    parameter int          HDISP    = FB_HDISP,
    parameter int          VDISP    = FB_VDISP,
    parameter logic [31:0] BASE_ADR = 32'h0,
    parameter int          BURST    = 64,
    parameter int          GAP      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  pat,
    input  logic [23:0] color,
    output logic        busy,
    output logic        done,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_ms,
    output logic        wb_we,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic        wb_ack,
    input  logic [31:0] wb_dat_sm
);

    localparam int XW  = $clog2(HDISP);
    localparam int YW  = $clog2(VDISP);
    localparam int IW  = $clog2(HDISP * VDISP);
    localparam int BCW = $clog2(BURST + 1);
    localparam int GCW = $clog2(GAP + 1);

    localparam logic [XW-1:0]  X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(VDISP - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(BURST - 1);
    localparam logic [GCW-1:0] G_LAST = GCW'(GAP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

    state_t          state, state_n;
    logic [XW-1:0]   x, x_n;
    logic [YW-1:0]   y, y_n;
    logic [IW-1:0]   idx, idx_n;
    logic [BCW-1:0]  bcnt, bcnt_n;
    logic [GCW-1:0]  gcnt, gcnt_n;
    pat_t            pat_q, pat_n;
    logic [23:0]     color_q, color_n;
    logic            cont_q, cont_n;
    logic            done_n;
    logic [23:0]     pixel;
    logic            unused_dat;

    assign unused_dat = ^wb_dat_sm;
    assign wb_cti     = 3'b000;
    assign wb_bte     = 2'b00;

    // Generator sees the next-cycle pixel so its output can be registered
    // straight into wb_dat_ms, aligned with wb_adr.
    fb_pattern_gen #(
        .HDISP (HDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_gen (
        .pat   (pat_n),
        .color (color_n),
        .x     (x_n),
        .y     (y_n),
        .pixel (pixel)
    );

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        idx_n   = idx;
        bcnt_n  = bcnt;
        gcnt_n  = gcnt;
        pat_n   = pat_q;
        color_n = color_q;
        cont_n  = cont_q;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_WRITE;
                    x_n     = '0;
                    y_n     = '0;
                    idx_n   = '0;
                    bcnt_n  = '0;
                    pat_n   = pat_t'(pat);
                    color_n = color;
                    cont_n  = continuous;
                end
            end
            ST_WRITE: begin
                if (wb_stb && wb_ack) begin
                    bcnt_n = bcnt + BCW'(1);
                    if (x == X_LAST && y == Y_LAST) begin
                        // Frame complete: wrap so a continuous restart begins at (0,0).
                        x_n     = '0;
                        y_n     = '0;
                        idx_n   = '0;
                        done_n  = 1'b1;
                        gcnt_n  = '0;
                        state_n = cont_q ? ST_GAP : ST_IDLE;
                    end else begin
                        idx_n = idx + IW'(1);
                        if (x == X_LAST) begin
                            x_n = '0;
                            y_n = y + YW'(1);
                        end else begin
                            x_n = x + XW'(1);
                        end
                        if (bcnt == B_LAST) begin
                            gcnt_n  = '0;
                            state_n = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gcnt == G_LAST) begin
                    bcnt_n  = '0;
                    state_n = ST_WRITE;
                end else begin
                    gcnt_n = gcnt + GCW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x         <= '0;
            y         <= '0;
            idx       <= '0;
            bcnt      <= '0;
            gcnt      <= '0;
            pat_q     <= PAT_SOLID;
            color_q   <= '0;
            cont_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wb_adr    <= '0;
            wb_dat_ms <= '0;
            wb_we     <= 1'b0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_sel    <= '0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            idx       <= idx_n;
            bcnt      <= bcnt_n;
            gcnt      <= gcnt_n;
            pat_q     <= pat_n;
            color_q   <= color_n;
            cont_q    <= cont_n;
            busy      <= (state_n != ST_IDLE);
            done      <= done_n;
            wb_adr    <= BASE_ADR + 32'({idx_n, 2'b00});
            wb_dat_ms <= {8'h00, pixel};
            wb_we     <= (state_n == ST_WRITE);
            wb_cyc    <= (state_n == ST_WRITE);
            wb_stb    <= (state_n == ST_WRITE);
            wb_sel    <= 4'b1111;
        end
    end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb_fb_pattern_writer: scoreboard bench for fb_pattern_writer on a 16x4 frame, bursts of 8, gaps of 3.
// Latency: expected writes queued at stimulus time, popped by a monitor on each accepted ack.
// Backpressure: the bench slave acks with zero wait, random 0-4 cycle wait, or stray acks outside stb.
module tb_fb_pattern_writer;

    localparam int          HD      = 16;
    localparam int          VD      = 4;
    localparam int          BURST_P = 8;
    localparam int          GAP_P   = 3;
    localparam logic [31:0] BASE    = 32'h0;
    localparam int          NPIX    = HD * VD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [23:0] color = 24'h0;
    logic        busy, done;
    logic [31:0] wb_adr, wb_dat_ms;
    logic        wb_we, wb_cyc, wb_stb;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack = 1'b0;
    logic [31:0] wb_dat_sm = 32'h0;

    fb_pattern_writer #(
        .HDISP    (HD),
        .VDISP    (VD),
        .BASE_ADR (BASE),
        .BURST    (BURST_P),
        .GAP      (GAP_P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .pat        (pat),
        .color      (color),
        .busy       (busy),
        .done       (done),
        .wb_adr     (wb_adr),
        .wb_dat_ms  (wb_dat_ms),
        .wb_we      (wb_we),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_sel     (wb_sel),
        .wb_cti     (wb_cti),
        .wb_bte     (wb_bte),
        .wb_ack     (wb_ack),
        .wb_dat_sm  (wb_dat_sm)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    int          acks = 0;
    int          done_cnt = 0;
    logic        exp_cont = 1'b0;
    logic        rand_wait = 1'b0;
    logic        junk_ack = 1'b0;
    logic [31:0] word_d4 = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference pixel for the 16x4 geometry; bar width is 16/8 = 2.
    function automatic logic [31:0] model_pix(input int p, input logic [23:0] c, input int x, input int y);
        logic [23:0] px;
        case (p)
            0: px = c;
            1: case (x / 2)
                   0:       px = 24'hFFFFFF;
                   1:       px = 24'hFFFF00;
                   2:       px = 24'h00FFFF;
                   3:       px = 24'h00FF00;
                   4:       px = 24'hFF00FF;
                   5:       px = 24'hFF0000;
                   6:       px = 24'h0000FF;
                   default: px = 24'h000000;
               endcase
            2: px = ((((x / 16) + (y / 16)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
            default: px = {8'(x % 256), 8'(y % 256), 8'((x + y) % 256)};
        endcase
        return {8'h00, px};
    endfunction

    task automatic push_frame(input int p, input logic [23:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({BASE + 32'(i * 4), model_pix(p, c, i % HD, i / HD)});
        end
    endtask

    // Slave: decides ack on the falling edge so the DUT samples a settled value.
    initial begin
        int  wcnt;
        logic pend;
        wcnt = 0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !wb_stb) begin
                pend   = 1'b0;
                wb_ack = rst_n && junk_ack;
            end else begin
                if (!pend) begin
                    pend = 1'b1;
                    wcnt = rand_wait ? int'($urandom_range(0, 4)) : 0;
                end
                if (wcnt == 0) begin
                    wb_ack = 1'b1;
                    pend   = 1'b0;
                end else begin
                    wcnt--;
                    wb_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted write and checks burst/gap shape.
    initial begin
        logic        hold_vld, prev_cyc, prev_done;
        logic [31:0] hold_adr, hold_dat;
        logic [63:0] exp_w;
        int          gap_len, burst_acks;
        hold_vld = 1'b0; prev_cyc = 1'b0; prev_done = 1'b0;
        hold_adr = '0; hold_dat = '0; gap_len = 0; burst_acks = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hold_vld = 1'b0; gap_len = 0; burst_acks = 0;
                prev_cyc = 1'b0; prev_done = 1'b0;
            end else begin
                if (wb_stb && hold_vld)
                    chk("hold_stable", {wb_adr, wb_dat_ms}, {hold_adr, hold_dat});
                if (wb_stb && wb_ack) begin
                    acks++;
                    burst_acks++;
                    if (wb_adr == 32'hD4) word_d4 = wb_dat_ms;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%h_%h expected=none", wb_adr, wb_dat_ms);
                    end else begin
                        exp_w = sb.pop_front();
                        chk("write_adr_dat", {wb_adr, wb_dat_ms}, exp_w);
                    end
                    chk("write_ctl", {54'h0, wb_we, wb_cyc, wb_sel, wb_cti, wb_bte},
                        {54'h0, 1'b1, 1'b1, 4'hF, 3'b000, 2'b00});
                    hold_vld = 1'b0;
                end else if (wb_stb) begin
                    hold_vld = 1'b1;
                    hold_adr = wb_adr;
                    hold_dat = wb_dat_ms;
                end else begin
                    hold_vld = 1'b0;
                end
                if (!wb_cyc && busy) gap_len++;
                if (wb_cyc && !prev_cyc && gap_len > 0) begin
                    chk("gap_len", 64'(gap_len), 64'(GAP_P));
                    gap_len = 0;
                end
                if (!wb_cyc && prev_cyc) begin
                    chk("burst_len", 64'(burst_acks), 64'(BURST_P));
                    burst_acks = 0;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_width", {63'h0, prev_done}, 64'h0);
                    chk("busy_at_done", {63'h0, busy}, {63'h0, exp_cont});
                end
                prev_cyc  = wb_cyc;
                prev_done = done;
            end
        end
    end

    task automatic pulse_start(input logic cont, input logic [1:0] p, input logic [23:0] c);
        @(posedge clk);
        #2;
        continuous = cont;
        pat        = p;
        color      = c;
        start      = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        chk("start_ctl", {60'h0, wb_cyc, wb_stb, wb_we, busy}, {60'h0, 4'hF});
        chk("start_adr", {32'h0, wb_adr}, {32'h0, BASE});
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("done_count", 64'(done_cnt), 64'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int base, n;
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctl", {58'h0, busy, done, wb_we, wb_cyc, wb_stb, 1'b0},  64'h0);
        chk("rst_bus", {wb_adr, wb_dat_ms}, 64'h0);
        chk("rst_sel_cti_bte", {55'h0, wb_sel, wb_cti, wb_bte}, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("sel_after_rst", {60'h0, wb_sel}, {60'h0, 4'hF});

        // Solid colour, zero-wait slave
        exp_cont = 1'b0;
        push_frame(0, 24'h123456, NPIX);
        base = done_cnt;
        pulse_start(1'b0, 2'd0, 24'h123456);
        wait_done(base + 1);
        idle_cycles(4);
        chk("solid_busy_low", {63'h0, busy}, 64'h0);
        chk("solid_sb_empty", 64'(sb.size()), 64'h0);

        // Colour bars, stray acks while stb is low
        junk_ack = 1'b1;
        push_frame(1, 24'h0, NPIX);
        base = done_cnt;
        pulse_start(1'b0, 2'd1, 24'h0);
        wait_done(base + 1);
        idle_cycles(4);
        junk_ack = 1'b0;
        chk("bars_sb_empty", 64'(sb.size()), 64'h0);

        // Gradient with random ack latency
        rand_wait = 1'b1;
        word_d4   = 32'h0;
        push_frame(3, 24'h0, NPIX);
        base = done_cnt;
        pulse_start(1'b0, 2'd3, 24'h0);
        wait_done(base + 1);
        idle_cycles(4);
        rand_wait = 1'b0;
        chk("grad_pix_5_3", {32'h0, word_d4}, {32'h0, 32'h00050308});
        chk("grad_sb_empty", 64'(sb.size()), 64'h0);

        // Continuous mode, two frames, starts during busy ignored
        exp_cont = 1'b1;
        push_frame(0, 24'hABCDEF, NPIX);
        push_frame(0, 24'hABCDEF, NPIX);
        base = done_cnt;
        pulse_start(1'b1, 2'd0, 24'hABCDEF);
        for (int k = 0; k < 2; k++) begin
            idle_cycles(k == 0 ? 10 : 60);
            pat   = 2'd2;
            color = 24'h000000;
            start = 1'b1;
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        wait_done(base + 2);
        rst_n = 1'b0;
        idle_cycles(2);
        chk("cont_sb_empty", 64'(sb.size()), 64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_cont = 1'b0;
        idle_cycles(2);

        // Reset mid-burst at pixel 20
        push_frame(0, 24'h111111, 20);
        base = acks;
        pulse_start(1'b0, 2'd0, 24'h111111);
        n = 0;
        while (acks - base < 20 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("rst_acks_before", 64'(acks - base), 64'd20);
        @(posedge clk);
        #2;
        chk("rst_pixel20_adr", {31'h0, wb_stb, wb_adr}, {31'h0, 1'b1, 32'h50});
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {61'h0, wb_cyc, wb_stb, busy}, 64'h0);
        idle_cycles(2);
        chk("rst_sb_empty", 64'(sb.size()), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Pattern pins change mid-fill: frame stays checkerboard, next start is solid
        push_frame(2, 24'h0, NPIX);
        base = done_cnt;
        pulse_start(1'b0, 2'd2, 24'h654321);
        idle_cycles(12);
        pat = 2'd0;
        wait_done(base + 1);
        idle_cycles(4);
        push_frame(0, 24'h654321, NPIX);
        pulse_start(1'b0, 2'd0, 24'h654321);
        wait_done(base + 2);
        idle_cycles(6);
        chk("final_sb_empty", 64'(sb.size()), 64'h0);
        chk("final_idle", {62'h0, busy, wb_cyc}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_pattern_writer.md
# fb_pattern_writer

- Wishbone master that fills the SDRAM framebuffer with a selectable test pattern.
- Sits directly upstream of the VGA reader: it writes the same linear 32-bit-per-pixel layout the reader fetches, at word address BASE_ADR + (y*HDISP + x)*4.
- Writes are issued in bounded bursts separated by idle gaps, so a downstream bus arbiter can interleave the VGA reader's fetches.

## Interface
Parameters:
- HDISP, 800, visible pixels per line
- VDISP, 480, visible lines per frame
- BASE_ADR, 32'h0, byte address of pixel (0,0)
- BURST, 64, acked writes per burst (≥1)
- GAP, 8, cycles with cyc low between bursts (≥1)

Ports:
- clk  in  1  Wishbone clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to fill one frame; ignored while busy
- continuous  in  1  sampled at start; 1 = restart the fill automatically after each frame
- pat  in  2  pattern select; sampled at start: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient
- color  in  24  {R,G,B} for pattern 0; sampled at start
- busy  out  1  high from the cycle after an accepted start until the return to IDLE
- done  out  1  one-cycle pulse when the last pixel of a frame is acked
- wb_adr  out  32  byte address
- wb_dat_ms  out  32  write data {8'h00,R,G,B}
- wb_we, wb_cyc, wb_stb  out  1  Wishbone controls
- wb_sel  out  4  always 4'b1111
- wb_cti, wb_bte  out  3/2  always 0 (classic cycles)
- wb_ack  in  1  slave acknowledge
- wb_dat_sm  in  32  unused

## Operation
- FSM states and transitions:
  - IDLE: on start, latch pat, color and continuous; clear x, y, burst_cnt; go to WRITE.
  - WRITE: cyc=stb=we=1. On each ack, advance x (and y, wrapping at HDISP/VDISP) and burst_cnt.
    - Ack of the last pixel (x=HDISP-1, y=VDISP-1): pulse done. Go to GAP if continuous, else IDLE.
    - Otherwise, ack with burst_cnt=BURST-1: go to GAP.
  - GAP: cyc=stb=0; count GAP cycles, then go to WRITE with burst_cnt=0.
    - If the gap follows a completed frame, x and y are already 0.
- Counters:
  - x width $clog2(HDISP); y width $clog2(VDISP).
  - Linear word index counts 0..HDISP*VDISP-1 alongside x/y, so no multiplier is needed.
  - wb_adr = BASE_ADR + {idx,2'b00}.
- Patterns (x,y are the current pixel):
  - 0 solid: color.
  - 1 colour bars: bar = x / (HDISP/8), computed by a comparator chain, not a divider. Colours for bars 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 2 checkerboard: x[4]^y[4] ? 000000 : FFFFFF (16×16 squares).
  - 3 gradient: R=x[7:0], G=y[7:0], B=(x+y)[7:0] (mod 256).
- Mid-fill behaviour:
  - start during busy is ignored.
  - Changes to pat, color or continuous during a fill have no effect until the next start.
- Clearing continuous requires reset; no stop input.

## Timing
- Reset value of every output is 0: busy, done, wb_adr, wb_dat_ms, wb_we, wb_cyc, wb_stb, wb_sel, wb_cti, wb_bte.
  - Reset mid-burst drops cyc/stb immediately (asynchronously); the FSM returns to IDLE with no partial state.
  - After rst_n rises, wb_sel reads 4'b1111 from the first clock.
- All outputs are registered.
- start at edge N → cyc/stb/we=1 with pixel (0,0) at edge N+1; busy=1 from edge N+1.
- adr/dat are stable while stb is high and no ack has arrived. They update at the same edge that samples the ack, so the next pixel is presented one cycle after the ack.
- Zero-wait slave: one pixel per cycle within a burst.
- done is high for the one cycle after the final ack. In non-continuous mode busy falls in the same cycle.
- Every GAP lasts exactly GAP cycles with cyc=0, including the gap after a frame in continuous mode.
- wb_ack while stb=0 is ignored.

## Structure
- Shared package fb_pkg:
  - pattern-select enum (PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_GRAD);
  - the eight-entry colour-bar constant array;
  - HDISP/VDISP defaults, shared with the VGA reader.
- One sub-module: fb_pattern_gen. It is purely combinational, (pat, color, x, y) → 24-bit pixel, and is registered inside the writer.
- The FSM and counters stay in the top module.

## Test plan
- HDISP=16, VDISP=4, BURST=8, GAP=3, zero-wait slave, pat=0, color=123456, start once → 64 writes with data 00123456 to addresses 0x00..0xFC; cyc low for exactly 3 cycles after each group of 8 acks; one done pulse; busy low afterwards.
- pat=1, same geometry → words at x=0,2,4,…,14 (bar width 2) read FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 on every line.
- Random 0–4 cycle ack delays, pat=3 → adr/dat held stable until ack; word at (x=5,y=3) is 00050308; no write is skipped or duplicated.
- continuous=1 → second frame restarts at BASE_ADR after a 3-cycle gap; done pulses once per frame; start pulses during busy have no effect.
- rst_n low mid-burst at pixel 20 → cyc, stb and busy go 0 before the next clock edge. After release, start restarts at address 0.
- pat changed from 2 to 0 mid-fill → the frame stays checkerboard; the next start produces the solid colour.
